// File: rtl/transmitter_phys_encoder.sv
// Registered 8b/10b transmit encoder with running disparity and a training ordered-set override.
// Optional data scrambler: define TX_PHYS_ENCODER_SCRAMBLE_EN.
module transmitter_phys_encoder #(
   parameter logic       RD_INIT  = 1'b0,
   parameter logic [7:0] TRAIN_D1 = 8'h4A,
   parameter logic [7:0] TRAIN_D2 = 8'hB5
) (
   input  logic       i_clk,
   input  logic       i_arst_n,
   input  logic       i_k_en,
   input  logic [7:0] i_byte,
   input  logic       i_train_en,
   output logic [9:0] o_symbol,
   output logic       o_rd,
   output logic       o_train_act,
   output logic       o_code_err
);

   localparam logic [0:0] ST_DATA   = 1'b0;
   localparam logic [0:0] ST_TRAIN  = 1'b1;
   localparam logic [7:0] K28_5     = 8'hBC;
   localparam logic [9:0] K28_5_RDN = 10'h17C;
   localparam logic [9:0] K28_5_RDP = 10'h283;

   logic [0:0] state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [9:0] sym_q, sym_d;
   logic       rd_q, rd_d;
   logic       act_q, act_d;
   logic       err_q, err_d;

   logic       enc_k;
   logic [7:0] enc_byte;
   logic       k_valid;
   logic [4:0] x;
   logic [2:0] y;
   logic [5:0] six_n, six;
   logic [3:0] four_n, four;
   logic       rd_mid;
   logic       alt7;

`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
   logic [15:0] lfsr_q, lfsr_d;

   function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
      logic [15:0] r;
      r = s;
      for (int unsigned n = 0; n < 8; n++) r = {r[14:0], r[15] ^ r[4] ^ r[3] ^ r[2]};
      return r;
   endfunction
`endif

   assign k_valid = (i_byte[4:0] == 5'd28) ||
                    ((i_byte[7:5] == 3'd7) && ((i_byte[4:0] == 5'd23) || (i_byte[4:0] == 5'd27) ||
                                               (i_byte[4:0] == 5'd29) || (i_byte[4:0] == 5'd30)));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      act_d    = 1'b0;
      err_d    = 1'b0;
      enc_k    = i_k_en;
      enc_byte = i_byte;
`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
      lfsr_d   = lfsr_q;
`endif
      if (state_q == ST_TRAIN || i_train_en) begin
         // Counter rests at 0 in DATA, so the entry cycle emits set symbol 0.
         act_d = 1'b1;
         unique case (cnt_q)
            2'd0:       begin enc_k = 1'b1; enc_byte = K28_5;    end
            2'd1, 2'd2: begin enc_k = 1'b0; enc_byte = TRAIN_D1; end
            default:    begin enc_k = 1'b0; enc_byte = TRAIN_D2; end
         endcase
         cnt_d = cnt_q + 2'd1;
         if (state_q == ST_DATA)
            state_d = ST_TRAIN;
         else if (cnt_q == 2'd3 && !i_train_en)
            state_d = ST_DATA;
      end else if (i_k_en && !k_valid) begin
         enc_byte = K28_5;
         err_d    = 1'b1;
      end
`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
      else if (!i_k_en) begin
         enc_byte = i_byte ^ lfsr_q[15:8];
         lfsr_d   = lfsr_adv8(lfsr_q);
      end
      if (enc_k && enc_byte == K28_5) lfsr_d = '1;
`endif
   end

   always_comb begin
      x = enc_byte[4:0];
      y = enc_byte[7:5];
      unique case (x)
         5'd0:  six_n = 6'b100111;  5'd1:  six_n = 6'b011101;  5'd2:  six_n = 6'b101101;
         5'd3:  six_n = 6'b110001;  5'd4:  six_n = 6'b110101;  5'd5:  six_n = 6'b101001;
         5'd6:  six_n = 6'b011001;  5'd7:  six_n = 6'b111000;  5'd8:  six_n = 6'b111001;
         5'd9:  six_n = 6'b100101;  5'd10: six_n = 6'b010101;  5'd11: six_n = 6'b110100;
         5'd12: six_n = 6'b001101;  5'd13: six_n = 6'b101100;  5'd14: six_n = 6'b011100;
         5'd15: six_n = 6'b010111;  5'd16: six_n = 6'b011011;  5'd17: six_n = 6'b100011;
         5'd18: six_n = 6'b010011;  5'd19: six_n = 6'b110010;  5'd20: six_n = 6'b001011;
         5'd21: six_n = 6'b101010;  5'd22: six_n = 6'b011010;  5'd23: six_n = 6'b111010;
         5'd24: six_n = 6'b110011;  5'd25: six_n = 6'b100110;  5'd26: six_n = 6'b010110;
         5'd27: six_n = 6'b110110;  5'd28: six_n = 6'b001110;  5'd29: six_n = 6'b101110;
         5'd30: six_n = 6'b011110;  default: six_n = 6'b101011;
      endcase
      if (enc_k && x == 5'd28) six_n = 6'b001111;
      // Table holds RD- codes; RD+ is the complement for unbalanced codes and D.7.
      six    = (rd_q && ($countones(six_n) != 3 || x == 5'd7)) ? ~six_n : six_n;
      rd_mid = ($countones(six_n) == 3) ? rd_q : ~rd_q;

      alt7 = !enc_k && y == 3'd7 &&
             (rd_mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                     : (x == 5'd17 || x == 5'd18 || x == 5'd20));
      if (enc_k) begin
         unique case (y)
            3'd0: four_n = 4'b1011;  3'd1: four_n = 4'b0110;  3'd2: four_n = 4'b1010;
            3'd3: four_n = 4'b1100;  3'd4: four_n = 4'b1101;  3'd5: four_n = 4'b0101;
            3'd6: four_n = 4'b1001;  default: four_n = 4'b0111;
         endcase
      end else if (alt7) begin
         four_n = 4'b0111;
      end else begin
         unique case (y)
            3'd0: four_n = 4'b1011;  3'd1: four_n = 4'b1001;  3'd2: four_n = 4'b0101;
            3'd3: four_n = 4'b1100;  3'd4: four_n = 4'b1101;  3'd5: four_n = 4'b1010;
            3'd6: four_n = 4'b0110;  default: four_n = 4'b1110;
         endcase
      end
      four  = (rd_mid && ($countones(four_n) != 2 || enc_k || y == 3'd3)) ? ~four_n : four_n;
      rd_d  = ($countones(four_n) == 2) ? rd_mid : ~rd_mid;
      sym_d = {four[0], four[1], four[2], four[3], six[0], six[1], six[2], six[3], six[4], six[5]};
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= ST_DATA;
         cnt_q   <= '0;
         sym_q   <= RD_INIT ? K28_5_RDP : K28_5_RDN;
         rd_q    <= RD_INIT;
         act_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
         lfsr_q  <= '1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sym_q   <= sym_d;
         rd_q    <= rd_d;
         act_q   <= act_d;
         err_q   <= err_d;
`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
         lfsr_q  <= lfsr_d;
`endif
      end
   end

   assign o_symbol    = sym_q;
   assign o_rd        = rd_q;
   assign o_train_act = act_q;
   assign o_code_err  = err_q;

endmodule

// File: tb/tb_transmitter_phys_encoder.sv
// Bench for transmitter_phys_encoder: directed vector table, training sequences and a randomized
// run against a table-based 8b/10b reference model (scrambler modelled when TX_PHYS_ENCODER_SCRAMBLE_EN).
module tb_transmitter_phys_encoder;

   localparam logic TB_RD_INIT = 1'b0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       k_en = 1'b0;
   logic [7:0] din = 8'h00;
   logic       train_en = 1'b0;
   logic [9:0] sym;
   logic       rd, act, err;

   always #5 clk = ~clk;

   transmitter_phys_encoder #(
      .RD_INIT (TB_RD_INIT),
      .TRAIN_D1(8'h4A),
      .TRAIN_D2(8'hB5)
   ) dut (
      .i_clk      (clk),
      .i_arst_n   (rst_n),
      .i_k_en     (k_en),
      .i_byte     (din),
      .i_train_en (train_en),
      .o_symbol   (sym),
      .o_rd       (rd),
      .o_train_act(act),
      .o_code_err (err)
   );

   int checks = 0;
   int errors = 0;

   // Full standard code tables, both disparity columns, abcdei / fghj with 'a' / 'f' as MSB.
   logic [5:0] M6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                           6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                           6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                           6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   logic [5:0] P6 [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
                           6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
                           6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                           6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
   logic [3:0] DM4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [3:0] DP4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
   logic [3:0] KM4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
   logic [3:0] KP4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

   logic       mrd;
   logic [8:0] pend[$];
   logic [9:0] e_sym;
   logic       e_rd, e_act, e_err;
`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
   logic [15:0] mlfsr;
   function automatic logic [15:0] lfsr8(input logic [15:0] s);
      logic [15:0] r;
      r = s;
      for (int n = 0; n < 8; n++) r = {r[14:0], r[15] ^ r[4] ^ r[3] ^ r[2]};
      return r;
   endfunction
`endif

   int   rdv, run;
   logic lastb, have_last;

   typedef struct {
      logic       k;
      logic [7:0] b;
      logic       t;
      logic [9:0] sym;
      logic       rd;
      logic       err;
      logic       act;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
      end
   endtask

   function automatic logic next_rd(input logic r, input int ones, input int half);
      if (ones > half) return 1'b1;
      if (ones < half) return 1'b0;
      return r;
   endfunction

   function automatic logic k_ok(input logic [7:0] b);
      int x, y;
      x = int'(b[4:0]);
      y = int'(b[7:5]);
      return (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
   endfunction

   function automatic logic [9:0] model_enc(input logic k, input logic [7:0] b, input logic rin,
                                            output logic rout);
      int x, y;
      logic [5:0] s;
      logic [3:0] f;
      logic r;
      logic [9:0] o;
      x = int'(b[4:0]);
      y = int'(b[7:5]);
      if (k && x == 28) s = rin ? 6'b110000 : 6'b001111;
      else              s = rin ? P6[x] : M6[x];
      r = next_rd(rin, $countones(s), 3);
      if (k) f = r ? KP4[y] : KM4[y];
      else if (y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) || (r && (x == 11 || x == 13 || x == 14))))
         f = r ? 4'b1000 : 4'b0111;
      else f = r ? DP4[y] : DM4[y];
      rout = next_rd(r, $countones(f), 2);
      for (int n = 0; n < 6; n++) o[n] = s[5-n];
      for (int n = 0; n < 4; n++) o[6+n] = f[3-n];
      return o;
   endfunction

   task automatic push_set(input logic with_k);
      if (with_k) pend.push_back({1'b1, 8'hBC});
      pend.push_back({1'b0, 8'h4A});
      pend.push_back({1'b0, 8'h4A});
      pend.push_back({1'b0, 8'hB5});
   endtask

   task automatic model_reset();
      mrd = TB_RD_INIT;
      pend.delete();
`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
      mlfsr = 16'hFFFF;
`endif
   endtask

   task automatic model_step(input logic k, input logic [7:0] b, input logic t);
      logic ek, nrd;
      logic [7:0] eb;
      logic [8:0] e;
      e_err = 1'b0;
      if (pend.size() != 0) begin
         e = pend.pop_front();
         ek = e[8];
         eb = e[7:0];
         e_act = 1'b1;
         if (pend.size() == 0 && t) push_set(1'b1);
      end else if (t) begin
         ek = 1'b1;
         eb = 8'hBC;
         e_act = 1'b1;
         push_set(1'b0);
      end else begin
         e_act = 1'b0;
         ek = k;
         eb = b;
         if (k && !k_ok(b)) begin
            eb = 8'hBC;
            e_err = 1'b1;
         end
`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
         else if (!k) begin
            eb = b ^ mlfsr[15:8];
            mlfsr = lfsr8(mlfsr);
         end
`endif
      end
`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
      if (ek && eb == 8'hBC) mlfsr = 16'hFFFF;
`endif
      e_sym = model_enc(ek, eb, mrd, nrd);
      mrd = nrd;
      e_rd = mrd;
   endtask

   task automatic step(input logic k, input logic [7:0] b, input logic t);
      @(negedge clk);
      k_en = k;
      din = b;
      train_en = t;
      model_step(k, b, t);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_sym"}, 32'(sym), 32'(e_sym));
      chk({tag, "_rd"},  32'(rd),  32'(e_rd));
      chk({tag, "_act"}, 32'(act), 32'(e_act));
      chk({tag, "_err"}, 32'(err), 32'(e_err));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_sym"}, 32'(sym), TB_RD_INIT ? 32'h283 : 32'h17C);
      chk({tag, "_rd"},  32'(rd),  32'(TB_RD_INIT));
      chk({tag, "_act"}, 32'(act), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic stream_chk(input logic [9:0] s);
      int   ones;
      logic ok;
      ones = 0;
      ok = 1'b1;
      for (int n = 0; n < 10; n++) begin
         if (have_last && s[n] == lastb) run++;
         else run = 1;
         lastb = s[n];
         have_last = 1'b1;
         if (run > 5) ok = 1'b0;
         if (s[n]) ones++;
         if (n == 5 || n == 9) begin
            rdv += (n == 5) ? 2 * ones - 6 : 2 * ones - 4;
            if (rdv != 1 && rdv != -1) ok = 1'b0;
            ones = 0;
         end
      end
      chk("stream_disp_run", 32'(ok), 32'd1);
      chk("stream_rd", 32'(rd), 32'(rdv > 0));
   endtask

   initial begin
      int cnt;
      model_reset();

      vecs.push_back('{1'b1, 8'hBC, 1'b0, 10'h17C, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'hBC, 1'b0, 10'h283, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 10'h0B9, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'h00, 1'b0, 10'h17C, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 10'h346, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'hBC, 1'b0, 10'h283, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'hB5, 1'b0, 10'h155, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'hFC, 1'b0, 10'h07C, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h4A, 1'b0, 10'h2AA, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'hF1, 1'b0, 10'h3B1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'hEB, 1'b0, 10'h04B, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'hF7, 1'b0, 10'h057, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h63, 1'b0, 10'h0E3, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'hF1, 1'b0, 10'h3B1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'hE1, 1'b0, 10'h283, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 10'h0B9, 1'b0, 1'b0, 1'b0});

      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

`ifdef TX_PHYS_ENCODER_SCRAMBLE_EN
      step(1'b1, 8'hBC, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("scr_first", 32'(sym), 32'h1CA);
      step(1'b1, 8'hBC, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("scr_restart", 32'(sym), 32'h235);
`else
      foreach (vecs[i]) begin
         step(vecs[i].k, vecs[i].b, vecs[i].t);
         chk("tbl_sym", 32'(sym), 32'(vecs[i].sym));
         chk("tbl_rd",  32'(rd),  32'(vecs[i].rd));
         chk("tbl_err", 32'(err), 32'(vecs[i].err));
         chk("tbl_act", 32'(act), 32'(vecs[i].act));
      end
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 8'h00, 1'b0);
         chk("d00_sym", 32'(sym), 32'h0B9);
         chk("d00_rd",  32'(rd),  32'd0);
      end
`endif

      // Single-cycle training request: one complete ordered set.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 8'(i * 37), i == 0);
         chk_model("tpulse");
         chk("tpulse_act", 32'(act), 32'(i < 4));
      end

      // Request held for 9 cycles: three complete sets, then data again.
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'($urandom_range(0, 255)), i < 9);
         chk_model("theld");
         chk("theld_act", 32'(act), 32'(i < 12));
         if (act) cnt++;
      end
      chk("theld_count", 32'(cnt), 32'd12);

      // Reset in the middle of a set.
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'hBC, 1'b0);
      chk("post_reset_sym", 32'(sym), TB_RD_INIT ? 32'h283 : 32'h17C);
      chk("post_reset_act", 32'(act), 32'd0);

      rdv = mrd ? 1 : -1;
      have_last = 1'b0;
      run = 0;
      lastb = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 63) == 0);
         chk_model("rand");
         stream_chk(sym);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
